// File: rtl/lane_sequencer_pkg.sv
// Shared definitions for the lane sequencer: sequencer states and memory bus widths.
package lane_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/lane_sequencer_lane_mux.sv
// Picks the active lane's register, mask, branch and memory slices out of the flat lane buses.
module lane_mux
  import lane_sequencer_pkg::*;
#(
  parameter int REG_W   = 16,
  parameter int N_REGS  = 8,
  parameter int N_LANES = 2,
  parameter int PC_W    = 15
) (
  input  logic [1:0]                       sel,
  input  logic [N_LANES*N_REGS*REG_W-1:0]  lane_regs,
  input  logic [N_LANES*N_REGS-1:0]        lane_wmask,
  input  logic [N_LANES-1:0]               lane_branch,
  input  logic [N_LANES*PC_W-1:0]          lane_target,
  input  logic [N_LANES*MEM_ADDR_W-1:0]    lane_mem_addr,
  input  logic [N_LANES*MEM_DATA_W-1:0]    lane_mem_wdata,
  input  logic [N_LANES-1:0]               lane_mem_we,
  output logic [N_REGS*REG_W-1:0]          sel_regs,
  output logic [N_REGS-1:0]                sel_wmask,
  output logic                             sel_branch,
  output logic [PC_W-1:0]                  sel_target,
  output logic [MEM_ADDR_W-1:0]            sel_mem_addr,
  output logic [MEM_DATA_W-1:0]            sel_mem_wdata,
  output logic                             sel_mem_we
);

  // An out-of-range select yields all zeros, so no lane can leak through.
  always_comb begin
    sel_regs      = '0;
    sel_wmask     = '0;
    sel_branch    = 1'b0;
    sel_target    = '0;
    sel_mem_addr  = '0;
    sel_mem_wdata = '0;
    sel_mem_we    = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (sel == 2'(k)) begin
        sel_regs      = lane_regs[k*N_REGS*REG_W +: N_REGS*REG_W];
        sel_wmask     = lane_wmask[k*N_REGS +: N_REGS];
        sel_branch    = lane_branch[k];
        sel_target    = lane_target[k*PC_W +: PC_W];
        sel_mem_addr  = lane_mem_addr[k*MEM_ADDR_W +: MEM_ADDR_W];
        sel_mem_wdata = lane_mem_wdata[k*MEM_DATA_W +: MEM_DATA_W];
        sel_mem_we    = lane_mem_we[k];
      end
    end
  end

endmodule

// File: rtl/lane_sequencer.sv
// Round-robin lane sequencer: each lane owns SLOT_CYC cycles and commits registers/pc at slot end.
module lane_sequencer
  import lane_sequencer_pkg::*;
#(
  parameter int REG_W     = 16,
  parameter int N_REGS    = 8,
  parameter int N_LANES   = 2,
  parameter int SLOT_CYC  = 2,
  parameter int PC_W      = 15,
  parameter int TERM_LINE = 256
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             run,
  input  logic [N_LANES*N_REGS*REG_W-1:0]  lane_regs,
  input  logic [N_LANES*N_REGS-1:0]        lane_wmask,
  input  logic [N_LANES-1:0]               lane_branch,
  input  logic [N_LANES*PC_W-1:0]          lane_target,
  input  logic [N_LANES*MEM_ADDR_W-1:0]    lane_mem_addr,
  input  logic [N_LANES*MEM_DATA_W-1:0]    lane_mem_wdata,
  input  logic [N_LANES-1:0]               lane_mem_we,
  output logic [N_REGS*REG_W-1:0]          regs,
  output logic [PC_W-1:0]                  pc,
  output logic [1:0]                       active_lane,
  output logic [MEM_ADDR_W-1:0]            mem_addr,
  output logic [MEM_DATA_W-1:0]            mem_wdata,
  output logic                             mem_we,
  output logic [N_REGS*REG_W-1:0]          display,
  output logic                             busy,
  output logic                             halted
);

  localparam int SC_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SLOT_CYC - 1);
  localparam logic [1:0]      LANE_LAST = 2'(N_LANES - 1);
  localparam logic [PC_W:0]   TERM      = (PC_W+1)'(TERM_LINE);

  seq_state_t             state_reg;
  logic [PC_W-1:0]        pc_reg;
  logic [1:0]             lane_reg;
  logic [SC_W-1:0]        slot_reg;
  logic                   busy_reg;
  logic                   halted_reg;
  logic [REG_W-1:0]       regs_reg    [N_REGS];
  logic [REG_W-1:0]       display_reg [N_REGS];

  logic [N_REGS*REG_W-1:0] sel_regs;
  logic [N_REGS-1:0]       sel_wmask;
  logic                    sel_branch;
  logic [PC_W-1:0]         sel_target;
  logic                    sel_mem_we;

  logic                    commit;
  logic [PC_W-1:0]         pc_inc;
  logic [PC_W-1:0]         pc_next;
  logic                    halt_hit;
  logic [1:0]              lane_next;

  lane_mux #(
    .REG_W   (REG_W),
    .N_REGS  (N_REGS),
    .N_LANES (N_LANES),
    .PC_W    (PC_W)
  ) u_lane_mux (
    .sel            (lane_reg),
    .lane_regs      (lane_regs),
    .lane_wmask     (lane_wmask),
    .lane_branch    (lane_branch),
    .lane_target    (lane_target),
    .lane_mem_addr  (lane_mem_addr),
    .lane_mem_wdata (lane_mem_wdata),
    .lane_mem_we    (lane_mem_we),
    .sel_regs       (sel_regs),
    .sel_wmask      (sel_wmask),
    .sel_branch     (sel_branch),
    .sel_target     (sel_target),
    .sel_mem_addr   (mem_addr),
    .sel_mem_wdata  (mem_wdata),
    .sel_mem_we     (sel_mem_we)
  );

  assign commit    = (state_reg == ST_RUN) && (slot_reg == SLOT_LAST);
  // Saturating increment keeps pc from wrapping even if TERM_LINE exceeds the pc range.
  assign pc_inc    = (pc_reg == {PC_W{1'b1}}) ? pc_reg : pc_reg + PC_W'(1);
  assign pc_next   = sel_branch ? sel_target : pc_inc;
  assign halt_hit  = {1'b0, pc_next} >= TERM;
  assign lane_next = (lane_reg == LANE_LAST) ? 2'd0 : lane_reg + 2'd1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= '0;
      lane_reg   <= 2'd0;
      slot_reg   <= '0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg  <= ST_RUN;
            busy_reg   <= 1'b1;
            halted_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (slot_reg == SLOT_LAST) begin
            slot_reg <= '0;
            lane_reg <= lane_next;
            pc_reg   <= pc_next;
            if (halt_hit) begin
              state_reg  <= ST_HALT;
              busy_reg   <= 1'b0;
              halted_reg <= 1'b1;
            end
          end else begin
            slot_reg <= slot_reg + SC_W'(1);
          end
        end
        ST_HALT: begin
          if (run) begin
            state_reg  <= ST_RUN;
            pc_reg     <= '0;
            busy_reg   <= 1'b1;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          busy_reg   <= 1'b0;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      always_ff @(posedge CLK) begin
        if (reset) begin
          regs_reg[gi]    <= '0;
          display_reg[gi] <= '0;
        end else begin
          if (commit && sel_wmask[gi]) begin
            regs_reg[gi] <= sel_regs[gi*REG_W +: REG_W];
          end
          display_reg[gi] <= regs_reg[gi];
        end
      end
      assign regs[gi*REG_W +: REG_W]    = regs_reg[gi];
      assign display[gi*REG_W +: REG_W] = display_reg[gi];
    end
  endgenerate

  assign pc          = pc_reg;
  assign active_lane = lane_reg;
  assign mem_we      = (state_reg == ST_RUN) && sel_mem_we;
  assign busy        = busy_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_lane_sequencer.sv
// Directed bench for lane_sequencer: walks commits, branches, halt, restart, mem_we gating and reset.
module tb_lane_sequencer;

  localparam int REG_W     = 16;
  localparam int N_REGS    = 8;
  localparam int N_LANES   = 2;
  localparam int SLOT_CYC  = 2;
  localparam int PC_W      = 15;
  localparam int TERM_LINE = 256;
  localparam int RW        = N_REGS*REG_W;

  logic                            CLK = 1'b0;
  logic                            reset;
  logic                            run;
  logic [N_LANES*N_REGS*REG_W-1:0] lane_regs;
  logic [N_LANES*N_REGS-1:0]       lane_wmask;
  logic [N_LANES-1:0]              lane_branch;
  logic [N_LANES*PC_W-1:0]         lane_target;
  logic [N_LANES*24-1:0]           lane_mem_addr;
  logic [N_LANES*16-1:0]           lane_mem_wdata;
  logic [N_LANES-1:0]              lane_mem_we;
  logic [RW-1:0]                   regs;
  logic [PC_W-1:0]                 pc;
  logic [1:0]                      active_lane;
  logic [23:0]                     mem_addr;
  logic [15:0]                     mem_wdata;
  logic                            mem_we;
  logic [RW-1:0]                   display;
  logic                            busy;
  logic                            halted;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] exp_regs;

  lane_sequencer #(
    .REG_W(REG_W), .N_REGS(N_REGS), .N_LANES(N_LANES),
    .SLOT_CYC(SLOT_CYC), .PC_W(PC_W), .TERM_LINE(TERM_LINE)
  ) dut (
    .CLK(CLK), .reset(reset), .run(run),
    .lane_regs(lane_regs), .lane_wmask(lane_wmask), .lane_branch(lane_branch),
    .lane_target(lane_target), .lane_mem_addr(lane_mem_addr),
    .lane_mem_wdata(lane_mem_wdata), .lane_mem_we(lane_mem_we),
    .regs(regs), .pc(pc), .active_lane(active_lane), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .display(display),
    .busy(busy), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_reg(input int lane, input int r, input logic [REG_W-1:0] v);
    lane_regs[(lane*N_REGS + r)*REG_W +: REG_W] = v;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0;
    lane_regs = '0; lane_wmask = '0; lane_branch = '0; lane_target = '0;
    lane_mem_addr = {24'h5A5A01, 24'hABCDE1};
    lane_mem_wdata = {16'h2222, 16'h1111};
    lane_mem_we = 2'b11;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_regs",    regs, '0);
    check("rst_pc",      RW'(pc), RW'(0));
    check("rst_lane",    RW'(active_lane), RW'(0));
    check("rst_display", display, '0);
    check("rst_busy",    RW'(busy), RW'(0));
    check("rst_halted",  RW'(halted), RW'(0));
    check("idle_mem_we", RW'(mem_we), RW'(0));
    check("idle_addr",   RW'(mem_addr), RW'(24'hABCDE1));
    check("idle_wdata",  RW'(mem_wdata), RW'(16'h1111));

    // Lane0 writes r0 only; lane1 writes r7 only; other slices carry junk that must be masked.
    lane_mem_we = 2'b00;
    for (int i = 0; i < N_REGS; i++) begin
      set_reg(0, i, 16'h1111);
      set_reg(1, i, 16'h5555);
    end
    set_reg(0, 0, 16'h1234);
    set_reg(1, 7, 16'hBEEF);
    lane_wmask = {8'h80, 8'h01};
    run = 1'b1;
    tick();
    run = 1'b0;
    check("start_busy", RW'(busy), RW'(1));
    check("start_pc",   RW'(pc), RW'(0));
    tick();
    check("slot0_regs", regs, '0);
    tick();
    exp_regs = '0;
    exp_regs[15:0] = 16'h1234;
    check("c1_regs",    regs, exp_regs);
    check("c1_pc",      RW'(pc), RW'(1));
    check("c1_lane",    RW'(active_lane), RW'(1));
    check("c1_display", display, '0);
    tick();
    check("c1_display_late", display, exp_regs);
    check("lane1_addr", RW'(mem_addr), RW'(24'h5A5A01));
    tick();
    exp_regs[RW-1 -: 16] = 16'hBEEF;
    check("c2_regs", regs, exp_regs);
    check("c2_pc",   RW'(pc), RW'(2));
    check("c2_lane", RW'(active_lane), RW'(0));

    // Branch to 255, then the next sequential commit reaches the halt line.
    lane_wmask = '0;
    lane_branch = 2'b01;
    lane_target[0 +: PC_W] = 15'd255;
    tick(); tick();
    check("br_pc",   RW'(pc), RW'(255));
    check("br_busy", RW'(busy), RW'(1));
    lane_mem_we = 2'b11;
    tick(); tick();
    check("halt_pc",     RW'(pc), RW'(256));
    check("halt_halted", RW'(halted), RW'(1));
    check("halt_busy",   RW'(busy), RW'(0));
    check("halt_mem_we", RW'(mem_we), RW'(0));
    lane_wmask = '1;
    tick(); tick(); tick();
    check("hold_regs", regs, exp_regs);
    check("hold_pc",   RW'(pc), RW'(256));

    // Restart from HALT and exercise mem_we forwarding per active lane.
    lane_wmask = '0;
    lane_branch = '0;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("rs_pc",     RW'(pc), RW'(0));
    check("rs_busy",   RW'(busy), RW'(1));
    check("rs_halted", RW'(halted), RW'(0));
    check("we_l0_11",  RW'(mem_we), RW'(1));
    lane_mem_we = 2'b10;
    #1;
    check("we_l0_10", RW'(mem_we), RW'(0));
    tick(); tick();
    check("we_l1_10", RW'(mem_we), RW'(1));
    check("rs_c_pc",  RW'(pc), RW'(1));

    // Out-of-range branch halts immediately without wrapping pc.
    lane_branch = 2'b10;
    lane_target[PC_W +: PC_W] = 15'd300;
    lane_mem_we = 2'b11;
    tick(); tick();
    check("far_pc",     RW'(pc), RW'(300));
    check("far_halted", RW'(halted), RW'(1));
    check("far_mem_we", RW'(mem_we), RW'(0));

    // Reset coincident with run and a commit cycle wins over both.
    lane_branch = '0;
    run = 1'b1;
    tick();
    run = 1'b0;
    lane_wmask = '1;
    tick();
    reset = 1'b1;
    run = 1'b1;
    tick();
    reset = 1'b0;
    run = 1'b0;
    check("rc_regs",    regs, '0);
    check("rc_pc",      RW'(pc), RW'(0));
    check("rc_lane",    RW'(active_lane), RW'(0));
    check("rc_display", display, '0);
    check("rc_busy",    RW'(busy), RW'(0));
    check("rc_halted",  RW'(halted), RW'(0));
    check("rc_mem_we",  RW'(mem_we), RW'(0));
    tick();
    check("rc_idle_regs", regs, '0);
    check("rc_idle_busy", RW'(busy), RW'(0));
    check("rc_idle_pc",   RW'(pc), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
